// File: rtl/fft8_frame_sequencer.sv
// Frame sequencer around a combinational 8-point real FFT core: gathers 8 serial samples,
// holds them on the core for a settle window, captures the 8 bins and streams them out.
module fft8_frame_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 4,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic [255:0]     core_vec,
  input  logic [511:0]     core_result,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [63:0]      out_data,
  output logic [2:0]       out_index,
  output logic             out_last,
  output logic             busy,
  output logic             frame_err,
  output logic [CNT_W-1:0] frame_count
);

  typedef enum logic [1:0] {StLoad, StSettle, StCapture, StDrain} state_e;

  localparam logic [7:0] SettleInit = 8'(SETTLE_CYCLES - 1);

  state_e      state;
  logic [2:0]  idx;
  logic        in_full;
  logic [7:0]  settle_cnt;
  logic [31:0] in_buf  [8];
  logic [63:0] out_buf [8];

  logic in_fire, out_fire, early_last, frame_done;

  assign in_ready   = (state == StLoad) || (state == StDrain && !in_full);
  assign in_fire    = in_valid && in_ready;
  assign out_fire   = out_valid && out_ready;
  assign early_last = in_fire && in_last && (idx != 3'd7);
  assign frame_done = in_fire && (idx == 3'd7);
  assign busy       = !(state == StLoad && idx == 3'd0);
  assign out_data   = out_buf[out_index];
  assign out_last   = out_valid && (out_index == 3'd7);

  // The input buffer drives the core directly, so it only moves on sample writes.
  always_comb begin
    core_vec = '0;
    for (int k = 0; k < 8; k++) core_vec[255-32*k -: 32] = in_buf[k];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= StLoad;
      idx         <= 3'd0;
      in_full     <= 1'b0;
      settle_cnt  <= 8'd0;
      out_index   <= 3'd0;
      out_valid   <= 1'b0;
      frame_err   <= 1'b0;
      frame_count <= '0;
      for (int k = 0; k < 8; k++) begin
        in_buf[k]  <= 32'd0;
        out_buf[k] <= 64'd0;
      end
    end else begin
      frame_err <= 1'b0;

      if (in_fire) begin
        if (early_last) begin
          idx       <= 3'd0;
          frame_err <= 1'b1;
        end else begin
          in_buf[idx] <= in_data;
          idx         <= idx + 3'd1;
          if (frame_done && !in_last) frame_err <= 1'b1;
        end
      end

      case (state)
        StLoad: begin
          if (frame_done) begin
            state      <= StSettle;
            settle_cnt <= SettleInit;
          end
        end
        StSettle: begin
          if (settle_cnt == 8'd0) state <= StCapture;
          else                    settle_cnt <= settle_cnt - 8'd1;
        end
        StCapture: begin
          for (int k = 0; k < 8; k++) out_buf[k] <= core_result[511-64*k -: 64];
          in_full   <= 1'b0;
          idx       <= 3'd0;
          out_index <= 3'd0;
          out_valid <= 1'b1;
          state     <= StDrain;
        end
        StDrain: begin
          if (frame_done) in_full <= 1'b1;
          if (out_fire) begin
            out_index <= out_index + 3'd1;
            if (out_index == 3'd7) begin
              out_valid   <= 1'b0;
              frame_count <= frame_count + 1'b1;
              // A frame finished while draining goes straight to settle, no load gap.
              if (in_full || frame_done) begin
                state      <= StSettle;
                settle_cnt <= SettleInit;
              end else begin
                state <= StLoad;
              end
            end
          end
        end
        default: state <= StLoad;
      endcase
    end
  end

endmodule

// File: tb/tb_fft8_frame_sequencer.sv
// Directed bench for fft8_frame_sequencer with a stand-in FFT core (known results for
// impulse and DC frames, a simple reversible mapping for anything else).
module tb_fft8_frame_sequencer;

  localparam int unsigned SETTLE = 4;
  localparam int unsigned CW     = 2;
  localparam logic [255:0] IMP   = {32'h3F800000, 224'h0};
  localparam logic [255:0] DC    = {8{32'h3F800000}};

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [31:0]   in_data = 32'd0;
  logic          in_ready, out_valid, out_last, busy, frame_err;
  logic [255:0]  core_vec;
  logic [511:0]  core_result;
  logic [63:0]   out_data;
  logic [2:0]    out_index;
  logic [CW-1:0] frame_count;

  int cyc = 0, nvec = 0, nfail = 0, exp_fc = 0, acc_cyc = 0, first_valid = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fft8_frame_sequencer #(.SETTLE_CYCLES(SETTLE), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .core_vec(core_vec), .core_result(core_result), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_index(out_index), .out_last(out_last),
    .busy(busy), .frame_err(frame_err), .frame_count(frame_count)
  );

  function automatic logic [63:0] gbin(input logic [31:0] s);
    return {s, ~s};
  endfunction

  function automatic logic [511:0] model_core(input logic [255:0] v);
    logic [511:0] r;
    r = '0;
    if (v == IMP) begin
      for (int k = 0; k < 8; k++) r[511-64*k -: 64] = {32'h3F800000, 32'h0};
    end else if (v == DC) begin
      r[511 -: 64] = {32'h41000000, 32'h0};
    end else begin
      for (int k = 0; k < 8; k++) r[511-64*k -: 64] = gbin(v[255-32*k -: 32]);
    end
    return r;
  endfunction

  assign core_result = model_core(core_vec);

  // Called at a negedge; returns at the negedge after the sample was taken.
  task automatic send(input logic [31:0] d, input logic last);
    int n = 0;
    in_valid = 1'b1; in_data = d; in_last = last;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin
      nvec++; nfail++;
      $display("FAIL send_timeout: in_ready=%b required 1", in_ready);
    end
    acc_cyc = cyc;
    @(negedge clk);
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic collect(input logic [63:0] exp [8], input bit bp, input string name);
    int got = 0, n = 0, ph = 0;
    bit stalled = 0, seen = 0;
    logic [63:0] sd;
    logic [2:0]  si;
    while (got < 8 && n < 300) begin
      out_ready = bp ? (ph % 3 == 0) : 1'b1;
      ph++;
      if (stalled) begin
        nvec++;
        if (out_data !== sd || out_index !== si) begin
          nfail++;
          $display("FAIL %s_stall: data=%h idx=%0d required data=%h idx=%0d",
                   name, out_data, out_index, sd, si);
        end
      end
      stalled = 0;
      if (out_valid) begin
        if (!seen) begin first_valid = cyc; seen = 1; end
        if (out_ready) begin
          nvec++;
          if (out_index !== 3'(got) || out_data !== exp[got] || out_last !== (got == 7)) begin
            nfail++;
            $display("FAIL %s_bin%0d: idx=%0d data=%h last=%b required idx=%0d data=%h last=%b",
                     name, got, out_index, out_data, out_last, got, exp[got], got == 7);
          end
          got++;
        end else begin
          stalled = 1; sd = out_data; si = out_index;
        end
      end
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    if (got < 8) begin
      nvec++; nfail++;
      $display("FAIL %s_timeout: got %0d bins required 8", name, got);
    end
  endtask

  task automatic check_fc(input string name);
    nvec++;
    if (frame_count !== CW'(exp_fc)) begin
      nfail++;
      $display("FAIL %s_frame_count: got %0d required %0d", name, frame_count, CW'(exp_fc));
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    nvec++;
    if (out_valid !== 1'b0 || out_last !== 1'b0 || busy !== 1'b0 || frame_err !== 1'b0 ||
        core_vec !== 256'd0 || frame_count !== '0) begin
      nfail++;
      $display("FAIL reset_state: valid=%b last=%b busy=%b err=%b vec=%h fc=%0d required all 0",
               out_valid, out_last, busy, frame_err, core_vec, frame_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    nvec++;
    if (in_ready !== 1'b1) begin
      nfail++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
  endtask

  task automatic test_impulse();
    logic [63:0] e [8];
    send(32'h3F800000, 1'b0);
    for (int i = 1; i < 7; i++) send(32'h0, 1'b0);
    send(32'h0, 1'b1);
    for (int k = 0; k < 8; k++) e[k] = {32'h3F800000, 32'h0};
    collect(e, 1'b0, "impulse");
    exp_fc++;
    check_fc("impulse");
  endtask

  task automatic test_dc();
    logic [63:0] e [8];
    int n = 0;
    for (int i = 0; i < 8; i++) send(32'h3F800000, i == 7);
    while (!out_valid && n < 50) begin
      nvec++;
      if (core_vec !== DC) begin
        nfail++;
        $display("FAIL dc_core_vec_hold: got %h required %h", core_vec, DC);
      end
      @(negedge clk);
      n++;
    end
    nvec++;
    if (cyc !== acc_cyc + int'(SETTLE) + 2) begin
      nfail++;
      $display("FAIL dc_latency: first valid at %0d required %0d", cyc, acc_cyc + SETTLE + 2);
    end
    for (int k = 0; k < 8; k++) e[k] = 64'd0;
    e[0] = {32'h41000000, 32'h0};
    collect(e, 1'b0, "dc");
    exp_fc++;
    check_fc("dc");
  endtask

  task automatic test_backpressure();
    logic [63:0] e [8];
    logic [31:0] s;
    for (int i = 0; i < 8; i++) begin
      s = 32'h4000_0000 + 32'(i) * 32'h0010_0000;
      e[i] = gbin(s);
      send(s, i == 7);
    end
    collect(e, 1'b1, "backpressure");
    exp_fc++;
    check_fc("backpressure");
  endtask

  task automatic test_back_to_back();
    logic [63:0] e1 [8];
    logic [63:0] e2 [8];
    logic [31:0] s [16];
    int f1 = 0, f2 = 0;
    for (int i = 0; i < 16; i++) begin
      s[i] = 32'hC100_0000 + 32'(i) * 32'h0001_0001;
      if (i < 8) e1[i] = gbin(s[i]); else e2[i-8] = gbin(s[i]);
    end
    fork
      begin
        for (int i = 0; i < 16; i++) send(s[i], i % 8 == 7);
        nvec++;
        if (in_ready !== 1'b0 || busy !== 1'b1) begin
          nfail++;
          $display("FAIL overlap_in_ready_drop: in_ready=%b busy=%b required 0 1", in_ready, busy);
        end
      end
      begin
        collect(e1, 1'b0, "overlap_f1");
        f1 = first_valid;
        collect(e2, 1'b0, "overlap_f2");
        f2 = first_valid;
      end
    join
    nvec++;
    if (f2 - f1 !== 8 + int'(SETTLE) + 1) begin
      nfail++;
      $display("FAIL overlap_frame_period: got %0d required %0d", f2 - f1, 8 + SETTLE + 1);
    end
    exp_fc += 2;
    check_fc("overlap");
  endtask

  task automatic test_framing();
    logic [63:0] e [8];
    logic [31:0] s;
    send(32'h1111_1111, 1'b0);
    send(32'h2222_2222, 1'b0);
    send(32'h3333_3333, 1'b1);
    nvec++;
    if (frame_err !== 1'b1 || busy !== 1'b0) begin
      nfail++;
      $display("FAIL early_last_err: err=%b busy=%b required 1 0", frame_err, busy);
    end
    @(negedge clk);
    nvec++;
    if (frame_err !== 1'b0) begin
      nfail++;
      $display("FAIL early_last_pulse: err=%b required 0", frame_err);
    end
    for (int i = 0; i < 8; i++) begin
      s = 32'h5000_0000 | 32'(i);
      e[i] = gbin(s);
      send(s, i == 7);
    end
    collect(e, 1'b0, "after_discard");
    exp_fc++;
    for (int i = 0; i < 8; i++) begin
      s = 32'h6000_0000 | 32'(i << 4);
      e[i] = gbin(s);
      send(s, 1'b0);
    end
    nvec++;
    if (frame_err !== 1'b1) begin
      nfail++;
      $display("FAIL missing_last_err: err=%b required 1", frame_err);
    end
    collect(e, 1'b0, "missing_last");
    exp_fc++;
    check_fc("framing");
  endtask

  task automatic test_reset_mid_drain();
    int n = 0;
    for (int i = 0; i < 8; i++) send(32'h7000_0000 + 32'(i), i == 7);
    out_ready = 1'b1;
    while (!(out_valid && out_index == 3'd3) && n < 100) begin @(negedge clk); n++; end
    nvec++;
    if (!(out_valid && out_index == 3'd3)) begin
      nfail++;
      $display("FAIL rst_reach_bin3: valid=%b idx=%0d required 1 3", out_valid, out_index);
    end
    rst_n = 1'b0;
    #1;
    nvec++;
    if (out_valid !== 1'b0 || out_last !== 1'b0) begin
      nfail++;
      $display("FAIL rst_async_valid: valid=%b last=%b required 0 0", out_valid, out_last);
    end
    out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_fc = 0;
    nvec++;
    if (in_ready !== 1'b1 || core_vec !== 256'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      nfail++;
      $display("FAIL rst_release: in_ready=%b vec=%h busy=%b valid=%b required 1 0 0 0",
               in_ready, core_vec, busy, out_valid);
    end
    check_fc("rst_release");
  endtask

  initial begin
    test_reset();
    test_impulse();
    test_dc();
    test_backpressure();
    test_back_to_back();
    test_framing();
    test_reset_mid_drain();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/fft8_frame_sequencer.md
Name: fft8_frame_sequencer

Overview:
- Sequences the combinational 8-point real-input FFT core (256-bit sample vector in, eight 64-bit complex bins out; IEEE-754 single precision, real in [63:32], imaginary in [31:0]).
- Collects 8 serial 32-bit samples over a valid/ready stream and holds them stable on the core input for a multicycle settle window.
- Captures all 8 bins and streams them out one per handshake, bin 0 first.
- Accepts the next frame while the current one drains.

Parameters:
- SETTLE_CYCLES, 4, cycles core_vec is held stable before capture (multicycle path budget); legal range 1..255.
- CNT_W, 16, width of frame_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample ready.
- in_data  in  32  real sample, IEEE-754 single.
- in_last  in  1  marks sample 7 of a frame.
- core_vec  out  256  to core input; sample k at [255-32k -: 32].
- core_result  in  512  from core; bin k at [511-64k -: 64].
- out_valid  out  1  bin valid.
- out_ready  in  1  bin ready.
- out_data  out  64  complex bin {re, im}.
- out_index  out  3  bin number 0..7.
- out_last  out  1  high with bin 7.
- busy  out  1  high in any state except LOAD with idx=0.
- frame_err  out  1  one-cycle framing-error pulse.
- frame_count  out  CNT_W  completed frames; wraps.

Behaviour:
- Reset (async assert, sync release):
  - State LOAD; idx, in_full, settle counter, out_index and frame_count = 0.
  - core_vec and output buffer = 0; out_valid, out_last, frame_err, busy = 0.
  - No handshake is taken while rst_n is low.
  - Reset mid-frame or mid-drain discards all data.
- Handshakes: a transfer occurs on a rising edge with valid&&ready. out_data, out_index and out_last hold stable while out_valid is high and out_ready is low.
- in_ready = (state==LOAD) || (state==DRAIN && !in_full).
- Input buffer: 8x32 register; the accepted sample is written at idx, then idx increments. The sample at idx 7 completes the frame.
- Framing:
  - in_last on a sample with idx<7 -> discard that sample and the partial frame, idx=0, frame_err pulses next cycle.
  - in_last low on the idx-7 sample -> the frame is still processed and frame_err pulses next cycle.
- States:
  - LOAD: accept samples. Completing a frame at cycle T -> SETTLE at T+1 with counter = SETTLE_CYCLES-1.
  - SETTLE: core_vec = input buffer, held constant. Counter decrements each cycle; at 0 -> CAPTURE.
  - CAPTURE (1 cycle): output buffer <= core_result; input buffer marked free (in_full=0, idx=0); -> DRAIN.
  - DRAIN:
    - out_valid=1, out_data = buffer[out_index].
    - Each output handshake increments out_index.
    - The handshake on bin 7 (out_last=1) increments frame_count, then:
      - if a complete frame is buffered (in_full, or its 8th sample is accepted in that same cycle) -> SETTLE;
      - else -> LOAD.
    - Input samples are accepted concurrently; the 8th sets in_full.
- Latency: 8th sample accepted at T (from LOAD) -> first out_valid at T+SETTLE_CYCLES+2.
- Throughput with out_ready=1: one frame per max(8, 8)+SETTLE_CYCLES+1 cycles, i.e. 8+SETTLE_CYCLES+1.
- core_vec changes only on input-buffer writes in LOAD/DRAIN, never during SETTLE/CAPTURE.
- Arithmetic: the block is data-transparent; no floating-point operations inside.
- frame_count wraps from 2^CNT_W-1 to 0.

Test Plan:
- Impulse: samples 3F800000, then 7 x 00000000, in_last on the 8th; out_ready=1 -> bins 0..7 each = {3F800000, 00000000}; out_last only on index 7; frame_count=1.
- DC: 8 x 3F800000 -> bin0 = {41000000, 00000000}; bins 1..7 have real and imaginary magnitude < 1e-6. With SETTLE_CYCLES=4: last accept at T, first out_valid at exactly T+6; core_vec is constant T+1..T+5.
- Backpressure: out_ready toggles 1,0,0,1,... -> out_data and out_index stable while stalled; all 8 bins are delivered once, in order, with no drop or duplication.
- Overlap: 16 back-to-back samples, out_ready=1 -> the second frame loads during the first drain; in_ready drops after its 8th sample; the second frame's bins follow with no LOAD gap; frame_count=2.
- Framing: in_last on the 3rd sample -> frame_err pulse and the partial frame is discarded; the next 8 samples form a valid frame. Separately, no in_last on the 8th sample -> frame_err pulse and output is still produced.
- Reset: assert rst_n=0 during DRAIN at bin 3 -> out_valid=0 immediately; after release in_ready=1, frame_count=0, core_vec=0.
